// File: rtl/washer_pkg.sv
// Shared definitions for the washing-machine plant model and its controller:
// default timing/level constants, controller state encodings and a small
// saturating-increment helper used by the plant timers.
package washer_pkg;

   localparam int LEVEL_MAX_DEF  = 8;
   localparam int CYCLE_TIME_DEF = 16;
   localparam int SPIN_TIME_DEF  = 12;
   localparam int DET_TIME_DEF   = 4;

   typedef enum logic [2:0] {
      CHECK_DOOR    = 3'd0,
      FILL_WATER    = 3'd1,
      ADD_DETERGENT = 3'd2,
      WASH_CYCLE    = 3'd3,
      DRAIN_WATER   = 3'd4,
      SPIN          = 3'd5
   } ctrl_state_t;

   // Increment by one but never move past the limit, so counters park at
   // their terminal value instead of wrapping.
   function automatic logic [7:0] sat_inc(input logic [7:0] value,
                                          input logic [7:0] limit);
      logic [7:0] result;
      result = value;
      if (value < limit) begin
         result = value + 8'd1;
      end
      return result;
   endfunction

endpackage

// File: rtl/wm_sat_timer.sv
// Saturating 8-bit cycle timer. Counts enabled edges up to TERM and holds
// there; clear wins over enable on the same edge. done is decoded from the
// count register so it never depends combinationally on enable/clear.
module wm_sat_timer
   import washer_pkg::*;
#(
   parameter int TERM = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic enable,
   input  logic clear,
   output logic done
);

   localparam logic [7:0] TERM_L = 8'(TERM);

   logic [7:0] count;

   // Count register: reset and clear both return to zero, clear first.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         count <= 8'd0;
      end else if (clear) begin
         count <= 8'd0;
      end else if (enable) begin
         count <= sat_inc(count, TERM_L);
      end
   end

   assign done = (count == TERM_L);

endmodule

// File: rtl/washer_plant.sv
// Behavioural plant model of a washing machine: water level, door latch,
// cycle/spin/detergent timers and a sticky safety fault. Every output comes
// straight from a register (or a decode of one) so the controller can drive
// its commands combinationally from these outputs without forming a loop.
module washer_plant
   import washer_pkg::*;
#(
   parameter int LEVEL_MAX  = LEVEL_MAX_DEF,
   parameter int CYCLE_TIME = CYCLE_TIME_DEF,
   parameter int SPIN_TIME  = SPIN_TIME_DEF,
   parameter int DET_TIME   = DET_TIME_DEF
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       fill_value_on,
   input  logic       drain_value_on,
   input  logic       motor_on,
   input  logic       door_lock,
   input  logic       soap_wash,
   input  logic       door_close_req,
   input  logic       door_open_req,
   output logic       door_close,
   output logic       filled,
   output logic       drained,
   output logic       detergent_added,
   output logic       cycle_timeout,
   output logic       spin_timeout,
   output logic [7:0] water_level,
   output logic       fault
);

   localparam logic [7:0] LEVEL_MAX_L = 8'(LEVEL_MAX);

   logic [7:0] level;
   logic [7:0] level_next;
   logic       fill_ok;
   logic       drain_ok;
   logic       soap_prev;
   logic       soap_rise;
   logic       spin_active;

   // Filling needs a closed, locked door; opening both valves at once holds.
   assign fill_ok  = fill_value_on & ~drain_value_on & door_lock & door_close
                     & (level < LEVEL_MAX_L);
   assign drain_ok = drain_value_on & ~fill_value_on & (level != 8'd0);

   // Next water level: step up, step down or hold, saturating at both ends.
   always_comb begin
      level_next = level;
      if (fill_ok) begin
         level_next = level + 8'd1;
      end else if (drain_ok) begin
         level_next = level - 8'd1;
      end
   end

   // Level register.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         level <= 8'd0;
      end else begin
         level <= level_next;
      end
   end

   // Door latch: a close request always wins; opening is refused while locked.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         door_close <= 1'b0;
      end else if (door_close_req) begin
         door_close <= 1'b1;
      end else if (door_open_req && !door_lock) begin
         door_close <= 1'b0;
      end
   end

   // Sticky fault: running the drum with the door open or filling unlocked.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         fault <= 1'b0;
      end else if ((motor_on && !door_close) || (fill_value_on && !door_lock)) begin
         fault <= 1'b1;
      end
   end

   // Previous soap_wash sample, used to spot the start of a detergent dose.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         soap_prev <= 1'b0;
      end else begin
         soap_prev <= soap_wash;
      end
   end

   assign soap_rise   = soap_wash & ~soap_prev;
   assign spin_active = drain_value_on & (level == 8'd0);

   wm_sat_timer #(.TERM(CYCLE_TIME)) u_cycle_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .enable  (motor_on),
      .clear   (~motor_on),
      .done    (cycle_timeout)
   );

   wm_sat_timer #(.TERM(SPIN_TIME)) u_spin_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .enable  (spin_active),
      .clear   (~spin_active),
      .done    (spin_timeout)
   );

   // The detergent timer starts on a soap_wash rising edge and keeps running
   // for as long as soap_wash stays high; dropping soap_wash clears it.
   wm_sat_timer #(.TERM(DET_TIME)) u_det_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .enable  (soap_wash & (soap_rise | soap_prev)),
      .clear   (~soap_wash),
      .done    (detergent_added)
   );

   assign water_level = level;
   assign filled      = (level == LEVEL_MAX_L);
   assign drained     = (level == 8'd0);

endmodule

// File: tb/tb_washer_plant.sv
// Self-checking bench for washer_plant with default parameters. A table of
// single-cycle vectors covers reset, door and level corner cases; hand-written
// loops cover the multi-cycle fill, cycle timer, spin timer, detergent timer
// and fault sequences. Expected outputs go into a scoreboard queue when the
// stimulus is driven and are popped and compared one cycle later.
module tb_washer_plant;

   // Stimulus bit order: reset_n fill drain motor lock soap close_req open_req
   typedef struct packed {
      logic reset_n;
      logic fill;
      logic drain;
      logic motor;
      logic lock;
      logic soap;
      logic close_req;
      logic open_req;
   } stim_t;

   // Flag order: filled drained det cto sto fault
   typedef struct packed {
      logic       door;
      logic [7:0] level;
      logic       filled;
      logic       drained;
      logic       det;
      logic       cto;
      logic       sto;
      logic       fault;
   } exp_t;

   typedef struct {
      stim_t s;
      exp_t  e;
   } vec_t;

   logic       clk;
   logic       reset_n;
   logic       fill_value_on;
   logic       drain_value_on;
   logic       motor_on;
   logic       door_lock;
   logic       soap_wash;
   logic       door_close_req;
   logic       door_open_req;
   logic       door_close;
   logic       filled;
   logic       drained;
   logic       detergent_added;
   logic       cycle_timeout;
   logic       spin_timeout;
   logic [7:0] water_level;
   logic       fault;

   int   checks;
   int   errors;
   exp_t sb[$];
   vec_t tbl[15];

   washer_plant dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .fill_value_on   (fill_value_on),
      .drain_value_on  (drain_value_on),
      .motor_on        (motor_on),
      .door_lock       (door_lock),
      .soap_wash       (soap_wash),
      .door_close_req  (door_close_req),
      .door_open_req   (door_open_req),
      .door_close      (door_close),
      .filled          (filled),
      .drained         (drained),
      .detergent_added (detergent_added),
      .cycle_timeout   (cycle_timeout),
      .spin_timeout    (spin_timeout),
      .water_level     (water_level),
      .fault           (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic compareBit(input string name, input logic act, input logic req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got %b want %b at %0t", name, act, req, $time);
      end
   endtask

   // Drive one vector and queue what the outputs must be after the next edge.
   task automatic applyStimulus(input stim_t s, input exp_t e);
      reset_n        = s.reset_n;
      fill_value_on  = s.fill;
      drain_value_on = s.drain;
      motor_on       = s.motor;
      door_lock      = s.lock;
      soap_wash      = s.soap;
      door_close_req = s.close_req;
      door_open_req  = s.open_req;
      sb.push_back(e);
   endtask

   // Pop the oldest expectation and compare it against the registered outputs.
   task automatic checkOutput(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s scoreboard: got empty queue want entry", tag);
         return;
      end
      e = sb.pop_front();
      compareBit({tag, " door_close"}, door_close, e.door);
      checks++;
      if (water_level !== e.level) begin
         errors++;
         $display("[TB] FAIL %s water_level: got %0d want %0d at %0t",
                  tag, water_level, e.level, $time);
      end
      compareBit({tag, " filled"}, filled, e.filled);
      compareBit({tag, " drained"}, drained, e.drained);
      compareBit({tag, " detergent_added"}, detergent_added, e.det);
      compareBit({tag, " cycle_timeout"}, cycle_timeout, e.cto);
      compareBit({tag, " spin_timeout"}, spin_timeout, e.sto);
      compareBit({tag, " fault"}, fault, e.fault);
   endtask

   task automatic step(input string tag, input stim_t s, input exp_t e);
      applyStimulus(s, e);
      @(posedge clk);
      #1;
      checkOutput(tag);
   endtask

   initial begin
      logic [7:0] lvl;
      checks = 0;
      errors = 0;
      applyStimulus(8'b0000_0000, {1'b0, 8'd0, 6'b010000});
      void'(sb.pop_back());

      tbl[0]  = '{8'b0000_0000, {1'b0, 8'd0, 6'b010000}}; // reset
      tbl[1]  = '{8'b1000_0010, {1'b1, 8'd0, 6'b010000}}; // close door
      tbl[2]  = '{8'b1000_1001, {1'b1, 8'd0, 6'b010000}}; // open while locked
      tbl[3]  = '{8'b1000_0011, {1'b1, 8'd0, 6'b010000}}; // close+open, close wins
      tbl[4]  = '{8'b1000_0001, {1'b0, 8'd0, 6'b010000}}; // open unlocked
      tbl[5]  = '{8'b1100_1000, {1'b0, 8'd0, 6'b010000}}; // fill, door open
      tbl[6]  = '{8'b1100_1010, {1'b1, 8'd0, 6'b010000}}; // fill as door closes
      tbl[7]  = '{8'b1100_1000, {1'b1, 8'd1, 6'b000000}}; // fill step
      tbl[8]  = '{8'b1110_1000, {1'b1, 8'd1, 6'b000000}}; // both valves hold
      tbl[9]  = '{8'b1010_1000, {1'b1, 8'd0, 6'b010000}}; // drain step
      tbl[10] = '{8'b1010_1000, {1'b1, 8'd0, 6'b010000}}; // drain saturates
      tbl[11] = '{8'b0010_0010, {1'b0, 8'd0, 6'b010000}}; // reset overrides
      tbl[12] = '{8'b1100_0000, {1'b0, 8'd0, 6'b010001}}; // fill unlocked: fault
      tbl[13] = '{8'b1000_0000, {1'b0, 8'd0, 6'b010001}}; // fault sticky
      tbl[14] = '{8'b0000_0000, {1'b0, 8'd0, 6'b010000}}; // reset clears fault

      for (int i = 0; i < 15; i++) begin
         step($sformatf("vec%0d", i), tbl[i].s, tbl[i].e);
      end

      // Fill to full and hold while fill stays on.
      step("close", 8'b1000_1010, {1'b1, 8'd0, 6'b010000});
      for (int i = 1; i <= 10; i++) begin
         lvl = (i > 8) ? 8'd8 : 8'(i);
         step($sformatf("fill%0d", i), 8'b1100_1000,
              {1'b1, lvl, (lvl == 8'd8), 1'b0, 4'b0000});
      end

      // Cycle timer reaches 16 and saturates; one idle cycle clears it.
      for (int i = 1; i <= 20; i++) begin
         step($sformatf("motor%0d", i), 8'b1001_1000,
              {1'b1, 8'd8, 3'b100, (i >= 16), 2'b00});
      end
      step("motor_off", 8'b1000_1000, {1'b1, 8'd8, 6'b100000});

      // Drain to empty, then 12 more edges for spin_timeout, which then holds.
      for (int i = 1; i <= 22; i++) begin
         lvl = (i >= 8) ? 8'd0 : 8'(8 - i);
         step($sformatf("drain%0d", i), 8'b1010_1000,
              {1'b1, lvl, 1'b0, (lvl == 8'd0), 2'b00, (i >= 20), 1'b0});
      end
      step("drain_off", 8'b1000_1000, {1'b1, 8'd0, 6'b010000});

      // Detergent after 4 edges, clears with soap_wash, restarts on a new edge.
      for (int i = 1; i <= 6; i++) begin
         step($sformatf("soap%0d", i), 8'b1000_1100,
              {1'b1, 8'd0, 2'b01, (i >= 4), 3'b000});
      end
      step("soap_off", 8'b1000_1000, {1'b1, 8'd0, 6'b010000});
      for (int i = 1; i <= 4; i++) begin
         step($sformatf("resoap%0d", i), 8'b1000_1100,
              {1'b1, 8'd0, 2'b01, (i >= 4), 3'b000});
      end
      step("resoap_off", 8'b1000_1000, {1'b1, 8'd0, 6'b010000});

      // Motor with the door open raises a fault that only reset clears.
      step("unlock_open", 8'b1000_0001, {1'b0, 8'd0, 6'b010000});
      step("motor_open", 8'b1001_0000, {1'b0, 8'd0, 6'b010001});
      for (int i = 1; i <= 3; i++) begin
         step($sformatf("fault_hold%0d", i), 8'b1000_0000, {1'b0, 8'd0, 6'b010001});
      end
      step("fault_reset", 8'b0000_0000, {1'b0, 8'd0, 6'b010000});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
